y86_decode_regread: RTL and testbench

- Decode-stage register-read block for the Y86-64 pipeline.
- Owns the architectural register file (rax..r14) as sequential state, and commits writeback results (W_dstE/W_valE, W_dstM/W_valM) into it.
- Computes source/destination IDs and selects forwarded operands.
- Registers everything into the D->E pipeline register. This is the read side paired with the writeback stage.

---
 rtl/y86_pkg.sv | 28 ++
 rtl/y86_regfile.sv | 35 +++
 rtl/y86_decode_regread.sv | 159 +++++++++++++++
 tb/tb_y86_decode_regread.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and sizes for the decode/register-read slice.
package y86_pkg;

    localparam int WORD = 64;
    localparam int NREG = 15;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [1:0] S_AOK = 2'd0;
    localparam logic [1:0] S_HLT = 2'd1;
    localparam logic [1:0] S_ADR = 2'd2;
    localparam logic [1:0] S_INS = 2'd3;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: two combinational reads, two writes where the
// memory-result port overrides the ALU-result port on the same register.
module y86_regfile
    import y86_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 src_a,
    input  logic [3:0]                 src_b,
    output logic [WORD-1:0]            rd_a,
    output logic [WORD-1:0]            rd_b,
    input  logic [3:0]                 wr_e_id,
    input  logic [WORD-1:0]            wr_e_val,
    input  logic [3:0]                 wr_m_id,
    input  logic [WORD-1:0]            wr_m_val,
    output logic [NREG-1:0][WORD-1:0]  regs
);

    logic [NREG-1:0][WORD-1:0] rf;

    // The M write is issued last so it wins when both ports name one register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf <= '0;
        end else begin
            if (wr_e_id != RNONE) rf[wr_e_id] <= wr_e_val;
            if (wr_m_id != RNONE) rf[wr_m_id] <= wr_m_val;
        end
    end

    assign rd_a = (src_a == RNONE) ? '0 : rf[src_a];
    assign rd_b = (src_b == RNONE) ? '0 : rf[src_b];
    assign regs = rf;

endmodule

// File: rtl/y86_decode_regread.sv
// Y86-64 decode stage: register IDs, forwarded operand selection, register
// file ownership and the D->E pipeline register.
module y86_decode_regread
    import y86_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      D_stat,
    input  logic [3:0]      D_icode,
    input  logic [3:0]      D_ifun,
    input  logic [3:0]      D_rA,
    input  logic [3:0]      D_rB,
    input  logic [WORD-1:0] D_valC,
    input  logic [WORD-1:0] D_valP,
    input  logic            E_bubble,
    input  logic [3:0]      e_dstE,
    input  logic [WORD-1:0] e_valE,
    input  logic [3:0]      M_dstE,
    input  logic [WORD-1:0] M_valE,
    input  logic [3:0]      M_dstM,
    input  logic [WORD-1:0] m_valM,
    input  logic [3:0]      W_dstE,
    input  logic [WORD-1:0] W_valE,
    input  logic [3:0]      W_dstM,
    input  logic [WORD-1:0] W_valM,
    output logic [3:0]      d_srcA,
    output logic [3:0]      d_srcB,
    output logic [1:0]      E_stat,
    output logic [3:0]      E_icode,
    output logic [3:0]      E_ifun,
    output logic [WORD-1:0] E_valC,
    output logic [WORD-1:0] E_valA,
    output logic [WORD-1:0] E_valB,
    output logic [3:0]      E_dstE,
    output logic [3:0]      E_dstM,
    output logic [3:0]      E_srcA,
    output logic [3:0]      E_srcB,
    output logic [WORD-1:0] reg0,
    output logic [WORD-1:0] reg1,
    output logic [WORD-1:0] reg2,
    output logic [WORD-1:0] reg3,
    output logic [WORD-1:0] reg4,
    output logic [WORD-1:0] reg5,
    output logic [WORD-1:0] reg6,
    output logic [WORD-1:0] reg7,
    output logic [WORD-1:0] reg8,
    output logic [WORD-1:0] reg9,
    output logic [WORD-1:0] reg10,
    output logic [WORD-1:0] reg11,
    output logic [WORD-1:0] reg12,
    output logic [WORD-1:0] reg13,
    output logic [WORD-1:0] reg14
);

    logic [3:0]                d_dstE, d_dstM;
    logic [WORD-1:0]           rf_a, rf_b, d_valA, d_valB;
    logic [NREG-1:0][WORD-1:0] regs;

    y86_regfile u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_a    (d_srcA),
        .src_b    (d_srcB),
        .rd_a     (rf_a),
        .rd_b     (rf_b),
        .wr_e_id  (W_dstE),
        .wr_e_val (W_valE),
        .wr_m_id  (W_dstM),
        .wr_m_val (W_valM),
        .regs     (regs)
    );

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            I_CMOV, I_RMMOV, I_OP, I_PUSH: d_srcA = D_rA;
            I_POP, I_RET:                  d_srcA = RSP;
            default:                       d_srcA = RNONE;
        endcase
        case (D_icode)
            I_OP, I_RMMOV, I_MRMOV:        d_srcB = D_rB;
            I_PUSH, I_POP, I_CALL, I_RET:  d_srcB = RSP;
            default:                       d_srcB = RNONE;
        endcase
        case (D_icode)
            I_CMOV, I_IRMOV, I_OP:         d_dstE = D_rB;
            I_PUSH, I_POP, I_CALL, I_RET:  d_dstE = RSP;
            default:                       d_dstE = RNONE;
        endcase
        case (D_icode)
            I_MRMOV, I_POP:                d_dstM = D_rA;
            default:                       d_dstM = RNONE;
        endcase
    end

    // Youngest producer first; a source of RNONE falls through to the file read, which is 0.
    always_comb begin
        d_valA = rf_a;
        if (D_icode == I_CALL || D_icode == I_JXX) d_valA = D_valP;
        else if (d_srcA != RNONE && d_srcA == e_dstE) d_valA = e_valE;
        else if (d_srcA != RNONE && d_srcA == M_dstM) d_valA = m_valM;
        else if (d_srcA != RNONE && d_srcA == M_dstE) d_valA = M_valE;
        else if (d_srcA != RNONE && d_srcA == W_dstM) d_valA = W_valM;
        else if (d_srcA != RNONE && d_srcA == W_dstE) d_valA = W_valE;

        d_valB = rf_b;
        if (d_srcB != RNONE && d_srcB == e_dstE) d_valB = e_valE;
        else if (d_srcB != RNONE && d_srcB == M_dstM) d_valB = m_valM;
        else if (d_srcB != RNONE && d_srcB == M_dstE) d_valB = M_valE;
        else if (d_srcB != RNONE && d_srcB == W_dstM) d_valB = W_valM;
        else if (d_srcB != RNONE && d_srcB == W_dstE) d_valB = W_valE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || E_bubble) begin
            E_stat  <= S_AOK;
            E_icode <= I_NOP;
            E_ifun  <= 4'h0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else begin
            E_stat  <= D_stat;
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_valC  <= D_valC;
            E_valA  <= d_valA;
            E_valB  <= d_valB;
            E_dstE  <= d_dstE;
            E_dstM  <= d_dstM;
            E_srcA  <= d_srcA;
            E_srcB  <= d_srcB;
        end
    end

    assign reg0  = regs[0];
    assign reg1  = regs[1];
    assign reg2  = regs[2];
    assign reg3  = regs[3];
    assign reg4  = regs[4];
    assign reg5  = regs[5];
    assign reg6  = regs[6];
    assign reg7  = regs[7];
    assign reg8  = regs[8];
    assign reg9  = regs[9];
    assign reg10 = regs[10];
    assign reg11 = regs[11];
    assign reg12 = regs[12];
    assign reg13 = regs[13];
    assign reg14 = regs[14];

endmodule

// File: tb/tb_y86_decode_regread.sv
// Directed-vector bench for the Y86-64 decode/register-read stage.
module tb_y86_decode_regread;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        E_bubble;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [1:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [63:0] regv [15];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    y86_decode_regread dut (
        .clk(clk), .rst_n(rst_n),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
        .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .reg0(regv[0]), .reg1(regv[1]), .reg2(regv[2]), .reg3(regv[3]),
        .reg4(regv[4]), .reg5(regv[5]), .reg6(regv[6]), .reg7(regv[7]),
        .reg8(regv[8]), .reg9(regv[9]), .reg10(regv[10]), .reg11(regv[11]),
        .reg12(regv[12]), .reg13(regv[13]), .reg14(regv[14])
    );

    task automatic idle();
        D_stat = 2'd0; D_icode = 4'h1; D_ifun = 4'h0;
        D_rA = 4'hF; D_rB = 4'hF; D_valC = 64'h0; D_valP = 64'h0;
        E_bubble = 1'b0;
        e_dstE = 4'hF; e_valE = 64'h0;
        M_dstE = 4'hF; M_valE = 64'h0; M_dstM = 4'hF; m_valM = 64'h0;
        W_dstE = 4'hF; W_valE = 64'h0; W_dstM = 4'hF; W_valM = 64'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int nz;
        idle();
        rst_n = 1'b0;
        D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2;
        W_dstE = 4'h3; W_valE = 64'h5;
        step();
        nz = 0;
        for (int i = 0; i < 15; i++) if (regv[i] !== 64'h0) nz++;
        n_cmp++;
        if (nz != 0) begin
            n_bad++; $display("FAIL reset_regs: %0d nonzero regs, reg3=%h, required all 0", nz, regv[3]);
        end
        n_cmp++;
        if (E_icode !== 4'h1) begin
            n_bad++; $display("FAIL reset_icode: got %h required 1", E_icode);
        end
        n_cmp++;
        if (E_dstE !== 4'hF) begin
            n_bad++; $display("FAIL reset_dstE: got %h required f", E_dstE);
        end
        n_cmp++;
        if (E_stat !== 2'd0) begin
            n_bad++; $display("FAIL reset_stat: got %0d required 0", E_stat);
        end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_write_priority();
        idle();
        W_dstE = 4'h2; W_valE = 64'h11;
        W_dstM = 4'h2; W_valM = 64'h22;
        step();
        idle();
        n_cmp++;
        if (regv[2] !== 64'h22) begin
            n_bad++; $display("FAIL wr_m_over_e: reg2 got %h required 22", regv[2]);
        end
        n_cmp++;
        if (regv[3] !== 64'h0) begin
            n_bad++; $display("FAIL wr_other_untouched: reg3 got %h required 0", regv[3]);
        end
    endtask

    task automatic test_forward_e_over_m();
        idle();
        D_icode = 4'h6; D_ifun = 4'h1; D_rA = 4'h0; D_rB = 4'h3; D_valC = 64'hABC;
        e_dstE = 4'h3; e_valE = 64'h99;
        M_dstE = 4'h3; M_valE = 64'h55;
        #1;
        n_cmp++;
        if (d_srcA !== 4'h0 || d_srcB !== 4'h3) begin
            n_bad++; $display("FAIL op_src_comb: srcA=%h srcB=%h required 0/3", d_srcA, d_srcB);
        end
        step();
        idle();
        n_cmp++;
        if (E_valB !== 64'h99) begin
            n_bad++; $display("FAIL fwd_e_over_m: E_valB got %h required 99", E_valB);
        end
        n_cmp++;
        if (E_dstE !== 4'h3 || E_icode !== 4'h6 || E_ifun !== 4'h1) begin
            n_bad++; $display("FAIL op_fields: dstE=%h icode=%h ifun=%h required 3/6/1", E_dstE, E_icode, E_ifun);
        end
        n_cmp++;
        if (E_valA !== 64'h0 || E_valC !== 64'hABC || E_dstM !== 4'hF) begin
            n_bad++; $display("FAIL op_vals: valA=%h valC=%h dstM=%h required 0/abc/f", E_valA, E_valC, E_dstM);
        end
    endtask

    task automatic test_mem_forward();
        // rA=7 hits both M paths (M_dstM wins); rB=8 only on W_dstE.
        idle();
        D_icode = 4'h6; D_rA = 4'h7; D_rB = 4'h8;
        M_dstM = 4'h7; m_valM = 64'hA1;
        M_dstE = 4'h7; M_valE = 64'hB2;
        W_dstE = 4'h8; W_valE = 64'hC3;
        step();
        idle();
        n_cmp++;
        if (E_valA !== 64'hA1) begin
            n_bad++; $display("FAIL fwd_mM_over_mE: E_valA got %h required a1", E_valA);
        end
        n_cmp++;
        if (E_valB !== 64'hC3 || regv[8] !== 64'hC3) begin
            n_bad++; $display("FAIL fwd_wE: E_valB=%h reg8=%h required c3/c3", E_valB, regv[8]);
        end
    endtask

    task automatic test_pop();
        idle();
        W_dstE = 4'h4; W_valE = 64'h100;
        step();
        idle();
        D_icode = 4'hB; D_rA = 4'h1; D_rB = 4'hF;
        step();
        idle();
        n_cmp++;
        if (E_srcA !== 4'h4 || E_srcB !== 4'h4) begin
            n_bad++; $display("FAIL pop_src: srcA=%h srcB=%h required 4/4", E_srcA, E_srcB);
        end
        n_cmp++;
        if (E_valA !== 64'h100 || E_valB !== 64'h100) begin
            n_bad++; $display("FAIL pop_vals: valA=%h valB=%h required 100/100", E_valA, E_valB);
        end
        n_cmp++;
        if (E_dstE !== 4'h4 || E_dstM !== 4'h1) begin
            n_bad++; $display("FAIL pop_dst: dstE=%h dstM=%h required 4/1", E_dstE, E_dstM);
        end
    endtask

    task automatic test_call_bubble();
        idle();
        D_icode = 4'h8; D_valP = 64'h40; D_valC = 64'h200;
        step();
        n_cmp++;
        if (E_valA !== 64'h40 || E_valB !== 64'h100 || E_dstE !== 4'h4) begin
            n_bad++; $display("FAIL call: valA=%h valB=%h dstE=%h required 40/100/4", E_valA, E_valB, E_dstE);
        end
        E_bubble = 1'b1;
        step();
        n_cmp++;
        if (E_icode !== 4'h1 || E_valA !== 64'h0 || E_valC !== 64'h0 || E_dstE !== 4'hF) begin
            n_bad++; $display("FAIL bubble: icode=%h valA=%h valC=%h dstE=%h required 1/0/0/f", E_icode, E_valA, E_valC, E_dstE);
        end
        idle();
        D_icode = 4'h7; D_valP = 64'h88;
        step();
        idle();
        n_cmp++;
        if (E_valA !== 64'h88 || E_icode !== 4'h7) begin
            n_bad++; $display("FAIL jxx_valp: valA=%h icode=%h required 88/7", E_valA, E_icode);
        end
    endtask

    task automatic test_rnone_source();
        idle();
        D_icode = 4'h3; D_rA = 4'hF; D_rB = 4'h9; D_valC = 64'h77;
        e_dstE = 4'hF; e_valE = 64'hDEAD;
        W_dstM = 4'hF; W_valM = 64'hBEEF;
        step();
        idle();
        n_cmp++;
        if (E_valA !== 64'h0 || E_valB !== 64'h0) begin
            n_bad++; $display("FAIL rnone_nomatch: valA=%h valB=%h required 0/0", E_valA, E_valB);
        end
        n_cmp++;
        if (E_dstE !== 4'h9 || E_srcA !== 4'hF || E_srcB !== 4'hF) begin
            n_bad++; $display("FAIL irmov_ids: dstE=%h srcA=%h srcB=%h required 9/f/f", E_dstE, E_srcA, E_srcB);
        end
    endtask

    task automatic test_rmmov_wfwd();
        idle();
        D_icode = 4'h4; D_rA = 4'h5; D_rB = 4'h6; D_stat = 2'd2;
        W_dstM = 4'h5; W_valM = 64'h7;
        #1;
        n_cmp++;
        if (regv[5] !== 64'h0) begin
            n_bad++; $display("FAIL rmmov_pre: reg5 got %h required 0", regv[5]);
        end
        step();
        idle();
        n_cmp++;
        if (E_valA !== 64'h7 || E_valB !== 64'h0) begin
            n_bad++; $display("FAIL rmmov_wfwd: valA=%h valB=%h required 7/0", E_valA, E_valB);
        end
        n_cmp++;
        if (regv[5] !== 64'h7 || E_stat !== 2'd2) begin
            n_bad++; $display("FAIL rmmov_commit: reg5=%h stat=%0d required 7/2", regv[5], E_stat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_write_priority();
        test_forward_e_over_m();
        test_mem_forward();
        test_pop();
        test_call_bubble();
        test_rnone_source();
        test_rmmov_wfwd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
